// File: rtl/pic_bus_pkg.sv
// Shared types and constants for the 8259A-compatible bus initiator and the
// hosts that drive it.
package pic_bus_pkg;

   localparam int PIC_TMR_W = 4;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_HOLD,
      ST_GAP,
      ST_INTA1,
      ST_INTA_GAP,
      ST_INTA2,
      ST_VEC
   } state_t;

   // Bus pin bundle; registered as one unit so every pin changes on the same edge.
   typedef struct packed {
      logic       cs_n;
      logic       wr_n;
      logic       rd_n;
      logic       inta_n;
      logic       a0;
      logic [7:0] dout;
      logic       dout_oe;
   } bus_t;

   localparam bus_t BUS_IDLE = '{cs_n: 1'b1, wr_n: 1'b1, rd_n: 1'b1, inta_n: 1'b1,
                                 a0: 1'b0, dout: 8'h00, dout_oe: 1'b0};

   // ICW1 / OCW3 field positions for hosts composing controller commands.
   localparam int         ICW1_INIT_BIT = 4;
   localparam int         ICW1_LTIM_BIT = 3;
   localparam int         ICW1_SNGL_BIT = 1;
   localparam int         ICW1_IC4_BIT  = 0;
   localparam logic [1:0] OCW3_SEL      = 2'b01;

   function automatic logic [7:0] icw1_word(input logic ltim, input logic sngl,
                                            input logic ic4);
      logic [7:0] w;
      w                = 8'h00;
      w[ICW1_INIT_BIT] = 1'b1;
      w[ICW1_LTIM_BIT] = ltim;
      w[ICW1_SNGL_BIT] = sngl;
      w[ICW1_IC4_BIT]  = ic4;
      return w;
   endfunction

endpackage

// File: rtl/pic_bus_master_pulse_timer.sv
// Loadable down-counter that times every multi-cycle bus state; done is high
// while the count sits at zero.
module pic_pulse_timer
   import pic_bus_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load,
   input  logic [PIC_TMR_W-1:0] load_val,
   output logic                 done
);

   logic [PIC_TMR_W-1:0] count;

   // NOTE: sequential state is assigned with <= so every register samples the
   // pre-edge values of its neighbours, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign done = (count == '0);

endmodule

// File: rtl/pic_bus_master.sv
// CPU-side initiator for the 8259A-compatible controller: register read/write
// cycles on cs_n/wr_n/rd_n/a0 and the two-pulse INTA vector fetch.
module pic_bus_master
   import pic_bus_pkg::*;
#(
   parameter int PULSE_CYCLES = 2,
   parameter int GAP_CYCLES   = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_rd,
   input  logic       cmd_a0,
   input  logic [7:0] cmd_data,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   input  logic       intr,
   output logic       vec_valid,
   output logic [7:0] vec_data,
   output logic       cs_n,
   output logic       wr_n,
   output logic       rd_n,
   output logic       inta_n,
   output logic       a0,
   output logic [7:0] dout,
   output logic       dout_oe,
   input  logic [7:0] din
);

   localparam logic [PIC_TMR_W-1:0] PULSE_LD = PIC_TMR_W'(PULSE_CYCLES - 1);
   localparam logic [PIC_TMR_W-1:0] GAP_LD   = PIC_TMR_W'(GAP_CYCLES - 1);

   state_t               state, next_state;
   bus_t                 bus_q, bus_d;
   logic                 lat_rd, lat_a0;
   logic [7:0]           lat_data;
   logic                 nxt_rd, nxt_a0;
   logic [7:0]           nxt_data;
   logic                 accept;
   logic                 tmr_load, tmr_done;
   logic [PIC_TMR_W-1:0] tmr_load_val;

   assign cmd_ready = (state == ST_IDLE) && !intr && !reset;
   assign accept    = cmd_valid && cmd_ready;

   // Outputs are registered from the next state, so the command being accepted
   // this edge must already steer a0/dout.
   assign nxt_rd   = accept ? cmd_rd   : lat_rd;
   assign nxt_a0   = accept ? cmd_a0   : lat_a0;
   assign nxt_data = accept ? cmd_data : lat_data;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // through the case leaves it unassigned and infers a latch.
      next_state = state;
      unique case (state)
         ST_IDLE: begin
            if (intr)        next_state = ST_INTA1;
            else if (accept) next_state = ST_SETUP;
         end
         ST_SETUP:    next_state = ST_STROBE;
         ST_STROBE:   if (tmr_done) next_state = ST_HOLD;
         ST_HOLD:     next_state = ST_GAP;
         ST_GAP:      if (tmr_done) next_state = ST_IDLE;
         ST_INTA1:    if (tmr_done) next_state = ST_INTA_GAP;
         ST_INTA_GAP: if (tmr_done) next_state = ST_INTA2;
         ST_INTA2:    if (tmr_done) next_state = ST_VEC;
         ST_VEC:      next_state = ST_GAP;
         default:     next_state = ST_IDLE;
      endcase
   end

   // The timer is reloaded with N-1 whenever a new state is entered.
   always_comb begin
      tmr_load     = (next_state != state);
      tmr_load_val = '0;
      unique case (next_state)
         ST_STROBE, ST_INTA1, ST_INTA2: tmr_load_val = PULSE_LD;
         ST_GAP, ST_INTA_GAP:           tmr_load_val = GAP_LD;
         default:                       tmr_load_val = '0;
      endcase
   end

   always_comb begin
      bus_d = BUS_IDLE;
      unique case (next_state)
         ST_SETUP, ST_STROBE, ST_HOLD: begin
            bus_d.cs_n    = 1'b0;
            bus_d.a0      = nxt_a0;
            bus_d.dout    = nxt_rd ? 8'h00 : nxt_data;
            bus_d.dout_oe = !nxt_rd;
            if (next_state == ST_STROBE) begin
               bus_d.wr_n = nxt_rd;
               bus_d.rd_n = !nxt_rd;
            end
         end
         ST_INTA1, ST_INTA2: bus_d.inta_n = 1'b0;
         default:            bus_d = BUS_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         bus_q     <= BUS_IDLE;
         lat_rd    <= 1'b0;
         lat_a0    <= 1'b0;
         lat_data  <= 8'h00;
         rsp_valid <= 1'b0;
         rsp_data  <= 8'h00;
         vec_valid <= 1'b0;
         vec_data  <= 8'h00;
      end else begin
         state     <= next_state;
         bus_q     <= bus_d;
         rsp_valid <= (next_state == ST_HOLD);
         vec_valid <= (next_state == ST_VEC);
         if (accept) begin
            lat_rd   <= cmd_rd;
            lat_a0   <= cmd_a0;
            lat_data <= cmd_data;
            rsp_data <= 8'h00;
         end else if (state == ST_STROBE && tmr_done && lat_rd) begin
            rsp_data <= din;
         end
         if (state == ST_INTA2 && tmr_done) vec_data <= din;
      end
   end

   pic_pulse_timer u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_load_val),
      .done     (tmr_done)
   );

   assign cs_n    = bus_q.cs_n;
   assign wr_n    = bus_q.wr_n;
   assign rd_n    = bus_q.rd_n;
   assign inta_n  = bus_q.inta_n;
   assign a0      = bus_q.a0;
   assign dout    = bus_q.dout;
   assign dout_oe = bus_q.dout_oe;

endmodule

// File: tb/tb_pic_bus_master.sv
// Scoreboard bench for pic_bus_master at default timing (PULSE=2, GAP=2):
// directed commands and acknowledges, responses checked by a separate monitor.
module tb_pic_bus_master;
   import pic_bus_pkg::*;

   logic       clk, reset;
   logic       cmd_valid, cmd_ready, cmd_rd, cmd_a0;
   logic [7:0] cmd_data;
   logic       rsp_valid, vec_valid, intr;
   logic [7:0] rsp_data, vec_data;
   logic       cs_n, wr_n, rd_n, inta_n, a0, dout_oe;
   logic [7:0] dout, din;

   int         vectors     = 0;
   int         miscompares = 0;
   int         vec_seen    = 0;
   logic [7:0] exp_rsp_q[$];
   logic [7:0] exp_vec_q[$];

   pic_bus_master dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_rd    (cmd_rd),
      .cmd_a0    (cmd_a0),
      .cmd_data  (cmd_data),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .intr      (intr),
      .vec_valid (vec_valid),
      .vec_data  (vec_data),
      .cs_n      (cs_n),
      .wr_n      (wr_n),
      .rd_n      (rd_n),
      .inta_n    (inta_n),
      .a0        (a0),
      .dout      (dout),
      .dout_oe   (dout_oe),
      .din       (din)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard whenever a completion pulse appears, and
   // watches the strobe exclusion rules every cycle.
   always @(negedge clk) begin
      if (!reset) begin
         check("rd_wr_exclusive", rd_n | wr_n, 1);
         check("inta_cs_exclusive", inta_n | cs_n, 1);
      end
      if (rsp_valid) begin
         if (exp_rsp_q.size() == 0) check("rsp_unexpected", rsp_valid, 0);
         else                       check("rsp_data", rsp_data, exp_rsp_q.pop_front());
      end
      if (vec_valid) begin
         vec_seen++;
         if (exp_vec_q.size() == 0) check("vec_unexpected", vec_valid, 0);
         else                       check("vec_data", vec_data, exp_vec_q.pop_front());
      end
   end

   // Drives a command and holds it until accepted; returns with the handshake
   // edge just passed. waited counts negedges spent with cmd_ready low.
   task automatic handshake(input logic rd, input logic a0v, input logic [7:0] data,
                            output int waited);
      cmd_rd    = rd;
      cmd_a0    = a0v;
      cmd_data  = data;
      cmd_valid = 1'b1;
      waited    = 0;
      #1;
      while (!cmd_ready && waited < 200) begin
         @(negedge clk);
         #1;
         waited++;
      end
      if (!cmd_ready) check("handshake_timeout", cmd_ready, 1);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   // Cycle-by-cycle pin check for cycles 1..7 after the handshake edge.
   task automatic check_cmd_timing(input logic rd, input logic a0v, input logic [7:0] data);
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         check($sformatf("cs_n@%0d", c), cs_n, (c <= 4) ? 0 : 1);
         check($sformatf("wr_n@%0d", c), wr_n, (!rd && (c == 2 || c == 3)) ? 0 : 1);
         check($sformatf("rd_n@%0d", c), rd_n, (rd && (c == 2 || c == 3)) ? 0 : 1);
         check($sformatf("dout_oe@%0d", c), dout_oe, (!rd && c <= 4) ? 1 : 0);
         check($sformatf("rsp_valid@%0d", c), rsp_valid, (c == 4) ? 1 : 0);
         check($sformatf("cmd_ready@%0d", c), cmd_ready, (c == 7) ? 1 : 0);
         if (c <= 4) begin
            check($sformatf("a0@%0d", c), a0, a0v);
            if (!rd) check($sformatf("dout@%0d", c), dout, data);
         end
      end
   endtask

   initial begin
      int waited;
      int vec_before;
      int low_cnt;

      reset = 1'b1; cmd_valid = 1'b0; cmd_rd = 1'b0; cmd_a0 = 1'b0;
      cmd_data = 8'h00; intr = 1'b0; din = 8'h00;

      repeat (3) @(negedge clk);
      check("rst_cs_n", cs_n, 1);
      check("rst_wr_n", wr_n, 1);
      check("rst_rd_n", rd_n, 1);
      check("rst_inta_n", inta_n, 1);
      check("rst_a0", a0, 0);
      check("rst_dout", dout, 0);
      check("rst_dout_oe", dout_oe, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_vec_valid", vec_valid, 0);
      check("rst_vec_data", vec_data, 0);
      check("rst_cmd_ready", cmd_ready, 0);
      reset = 1'b0;
      #1 check("post_rst_cmd_ready", cmd_ready, 1);
      @(negedge clk);

      // Register write, ICW1 with SNGL and IC4.
      exp_rsp_q.push_back(8'h00);
      handshake(1'b0, 1'b0, 8'h13, waited);
      check("wr_wait", waited, 0);
      check_cmd_timing(1'b0, 1'b0, 8'h13);

      // Register read.
      din = 8'hA5;
      exp_rsp_q.push_back(8'hA5);
      handshake(1'b1, 1'b1, 8'hFF, waited);
      check_cmd_timing(1'b1, 1'b1, 8'hFF);

      // OCW3 write (read-IRR selector) on a0=0, then another read.
      exp_rsp_q.push_back(8'h00);
      handshake(1'b0, 1'b0, 8'h0A, waited);
      check_cmd_timing(1'b0, 1'b0, 8'h0A);
      din = 8'h3C;
      exp_rsp_q.push_back(8'h3C);
      handshake(1'b1, 1'b0, 8'h00, waited);
      check_cmd_timing(1'b1, 1'b0, 8'h00);

      // Interrupt acknowledge from IDLE.
      din  = 8'h4B;
      intr = 1'b1;
      exp_vec_q.push_back(8'h4B);
      #1 check("ack_cmd_ready_blocked", cmd_ready, 0);
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (c == 2) intr = 1'b0;
         check($sformatf("ack_inta_n@%0d", c), inta_n,
               (c == 1 || c == 2 || c == 5 || c == 6) ? 0 : 1);
         check($sformatf("ack_cs_n@%0d", c), cs_n, 1);
         check($sformatf("ack_dout_oe@%0d", c), dout_oe, 0);
         check($sformatf("ack_vec_valid@%0d", c), vec_valid, (c == 7) ? 1 : 0);
      end

      // Collision: intr and a command raised together; acknowledge wins.
      din  = 8'h77;
      intr = 1'b1;
      exp_vec_q.push_back(8'h77);
      exp_rsp_q.push_back(8'h00);
      fork
         begin
            repeat (3) @(negedge clk);
            intr = 1'b0;
         end
      join_none
      vec_before = vec_seen;
      handshake(1'b0, 1'b1, 8'h5A, waited);
      check("collision_wait", waited, 10);
      check("collision_vec_first", vec_seen - vec_before, 1);
      check_cmd_timing(1'b0, 1'b1, 8'h5A);

      // intr drops during INTA_GAP: one full acknowledge, no re-trigger.
      din     = 8'hE1;
      intr    = 1'b1;
      low_cnt = 0;
      exp_vec_q.push_back(8'hE1);
      vec_before = vec_seen;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (c == 3) intr = 1'b0;
         if (!inta_n) low_cnt++;
         check($sformatf("drop_vec_valid@%0d", c), vec_valid, (c == 7) ? 1 : 0);
      end
      check("drop_inta_low_cycles", low_cnt, 4);
      check("drop_vec_count", vec_seen - vec_before, 1);

      // Reset in the second STROBE cycle of a write aborts it silently.
      din = 8'h00;
      handshake(1'b0, 1'b1, 8'hC3, waited);
      repeat (3) @(negedge clk);
      check("abort_wr_n_strobe2", wr_n, 0);
      reset = 1'b1;
      @(negedge clk);
      check("abort_cs_n", cs_n, 1);
      check("abort_wr_n", wr_n, 1);
      check("abort_rd_n", rd_n, 1);
      check("abort_inta_n", inta_n, 1);
      check("abort_dout_oe", dout_oe, 0);
      check("abort_rsp_valid", rsp_valid, 0);
      check("abort_cmd_ready", cmd_ready, 0);
      reset = 1'b0;
      #1 check("abort_ready_after", cmd_ready, 1);
      repeat (6) @(negedge clk);

      exp_rsp_q.push_back(8'h00);
      handshake(1'b0, 1'b1, 8'h66, waited);
      check("post_abort_wait", waited, 0);
      check_cmd_timing(1'b0, 1'b1, 8'h66);

      repeat (5) @(negedge clk);
      check("rsp_queue_drained", exp_rsp_q.size(), 0);
      check("vec_queue_drained", exp_vec_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
